// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline stage registers / data-memory handshake
// and the hazard controller. The pipeline side is the master; the controller
// is the slave that returns the stage-register enables, clears and status.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_addr1;
    logic [4:0]       id_addr2;
    logic             id_uses2;
    logic [4:0]       ex_addr_dst;
    logic             ex_reg_rw;
    logic             ex_is_load;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             halt_req;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_clr;
    logic             idex_clr;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_addr1, id_addr2, id_uses2, ex_addr_dst, ex_reg_rw,
               ex_is_load, br_taken, mem_req, mem_ack, halt_req,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr,
               halted, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_addr1, id_addr2, id_uses2, ex_addr_dst, ex_reg_rw,
               ex_is_load, br_taken, mem_req, mem_ack, halt_req,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr,
               halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: resolves memory-wait freezes, debug halt,
// taken-branch flushes and load-use bubbles for a 5-stage core, and keeps
// saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Last MEM_WAIT count before the wait is force-released.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       mem_err_q, mem_err_d;

    logic tmo;
    logic lu;
    logic freeze;
    logic pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr;

    // Hazard decode terms for the current cycle.
    always_comb begin
        tmo = (state_q == MEM_WAIT) && (tcnt_q == TMO_LAST);
        lu  = bus.ex_is_load && bus.ex_reg_rw && (bus.ex_addr_dst != 5'd0) &&
              ((bus.ex_addr_dst == bus.id_addr1) ||
               (bus.id_uses2 && (bus.ex_addr_dst == bus.id_addr2)));
        freeze = ((state_q == MEM_WAIT) && !bus.mem_ack && !tmo) ||
                 ((state_q == RUN) && bus.mem_req && !bus.mem_ack) ||
                 (state_q == HALT);
    end

    // Stage enables/clears, priority freeze > branch > load-use; all quiet in reset.
    always_comb begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        ifid_clr = 1'b0;
        idex_clr = 1'b0;
        if (rst && !freeze) begin
            if (bus.br_taken) begin
                // Branch wins over load-use: the ID instruction is squashed anyway.
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID, inject one bubble into ID/EX.
                idex_we  = 1'b1;
                idex_clr = 1'b1;
                exmem_we = 1'b1;
            end else begin
                pc_we    = 1'b1;
                ifid_we  = 1'b1;
                idex_we  = 1'b1;
                exmem_we = 1'b1;
            end
        end
    end

    // Next-state logic for the RUN / MEM_WAIT / HALT sequencer.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        mem_err_d = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    state_d = MEM_WAIT;
                    tcnt_d  = 8'd0;
                end else if (bus.halt_req && !bus.mem_req) begin
                    state_d = HALT;
                end
            end
            MEM_WAIT: begin
                tcnt_d = tcnt_q + 8'd1;
                // An ack coinciding with the timeout is a normal completion.
                if (bus.mem_ack) begin
                    state_d = RUN;
                end else if (tmo) begin
                    state_d   = RUN;
                    mem_err_d = 1'b1;
                end
            end
            HALT: begin
                if (!bus.halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Sequencer state, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            tcnt_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Counter 0 counts stalled cycles outside HALT, counter 1 counts applied flushes.
    logic [1:0]            cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_val;

    assign cnt_inc[0] = !pc_we && (state_q != HALT);
    assign cnt_inc[1] = bus.br_taken && !freeze;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;

            // Saturating increment; sticks at all-ones.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    assign bus.pc_we     = pc_we;
    assign bus.ifid_we   = ifid_we;
    assign bus.idex_we   = idex_we;
    assign bus.exmem_we  = exmem_we;
    assign bus.ifid_clr  = ifid_clr;
    assign bus.idex_clr  = idex_clr;
    assign bus.halted    = rst && (state_q == HALT);
    assign bus.mem_err   = mem_err_q;
    assign bus.stall_cnt = cnt_val[0];
    assign bus.flush_cnt = cnt_val[1];
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch priority, memory
// wait with ack and with timeout, debug halt and asynchronous reset.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(15),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Packed {pc_we, ifid_we, idex_we, exmem_we, ifid_clr, idex_clr}.
    function automatic logic [31:0] ctl();
        return {26'd0, bus_if.pc_we, bus_if.ifid_we, bus_if.idex_we,
                bus_if.exmem_we, bus_if.ifid_clr, bus_if.idex_clr};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.id_addr1    = 5'd0;
        bus_if.id_addr2    = 5'd0;
        bus_if.id_uses2    = 1'b0;
        bus_if.ex_addr_dst = 5'd0;
        bus_if.ex_reg_rw   = 1'b0;
        bus_if.ex_is_load  = 1'b0;
        bus_if.br_taken    = 1'b0;
        bus_if.mem_req     = 1'b0;
        bus_if.mem_ack     = 1'b0;
        bus_if.halt_req    = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();

        // Reset held
        #2;
        check("rst_ctl", ctl(), 32'h00);
        check("rst_halted", {31'd0, bus_if.halted}, 32'd0);
        check("rst_stall", {16'd0, bus_if.stall_cnt}, 32'd0);
        check("rst_merr", {31'd0, bus_if.mem_err}, 32'd0);
        #10 rst = 1'b1;
        next();
        #2 check("idle_ctl", ctl(), 32'h3C);

        // Load-use on rs
        bus_if.ex_is_load = 1'b1; bus_if.ex_reg_rw = 1'b1;
        bus_if.ex_addr_dst = 5'd5; bus_if.id_addr1 = 5'd5;
        #2 check("lu_rs_ctl", ctl(), 32'h0D);
        next();
        clear_inputs();
        check("lu_rs_stall", {16'd0, bus_if.stall_cnt}, 32'd1);

        // Load into r0 never stalls
        bus_if.ex_is_load = 1'b1; bus_if.ex_reg_rw = 1'b1;
        #2 check("lu_r0_ctl", ctl(), 32'h3C);
        next();
        check("lu_r0_stall", {16'd0, bus_if.stall_cnt}, 32'd1);

        // rt match ignored unless id_uses2
        bus_if.ex_addr_dst = 5'd7; bus_if.id_addr2 = 5'd7;
        #2 check("rt_nouse_ctl", ctl(), 32'h3C);
        next();
        bus_if.id_uses2 = 1'b1;
        #2 check("rt_use_ctl", ctl(), 32'h0D);
        next();
        clear_inputs();
        check("rt_use_stall", {16'd0, bus_if.stall_cnt}, 32'd2);

        // Branch overrides coincident load-use
        bus_if.ex_is_load = 1'b1; bus_if.ex_reg_rw = 1'b1;
        bus_if.ex_addr_dst = 5'd5; bus_if.id_addr1 = 5'd5; bus_if.br_taken = 1'b1;
        #2 check("br_lu_ctl", ctl(), 32'h3F);
        next();
        clear_inputs();
        check("br_flush", {16'd0, bus_if.flush_cnt}, 32'd1);
        check("br_stall", {16'd0, bus_if.stall_cnt}, 32'd2);

        // Memory wait, ack on 4th cycle; branch held across the freeze
        bus_if.mem_req = 1'b1;
        #2 check("mw_c1_ctl", ctl(), 32'h00);
        next();
        #2 check("mw_c2_ctl", ctl(), 32'h00);
        next();
        bus_if.br_taken = 1'b1;
        #2 check("mw_c3_ctl", ctl(), 32'h00);
        next();
        bus_if.mem_ack = 1'b1;
        #2 check("mw_ack_ctl", ctl(), 32'h3F);
        next();
        clear_inputs();
        check("mw_stall", {16'd0, bus_if.stall_cnt}, 32'd5);
        check("mw_flush", {16'd0, bus_if.flush_cnt}, 32'd2);
        check("mw_merr", {31'd0, bus_if.mem_err}, 32'd0);
        #2 check("mw_idle_ctl", ctl(), 32'h3C);

        // Memory timeout: 15 frozen cycles, release on the 16th
        bus_if.mem_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #2 check($sformatf("tmo_frz%0d", i), ctl(), 32'h00);
            next();
        end
        #2 check("tmo_rel_ctl", ctl(), 32'h3C);
        check("tmo_rel_merr", {31'd0, bus_if.mem_err}, 32'd0);
        next();
        clear_inputs();
        check("tmo_merr", {31'd0, bus_if.mem_err}, 32'd1);
        check("tmo_stall", {16'd0, bus_if.stall_cnt}, 32'd20);
        next();
        next();
        check("tmo_sticky", {31'd0, bus_if.mem_err}, 32'd1);

        // Debug halt
        bus_if.halt_req = 1'b1;
        #2 check("hlt_req_ctl", ctl(), 32'h3C);
        check("hlt_req_hlt", {31'd0, bus_if.halted}, 32'd0);
        next();
        check("hlt_halted", {31'd0, bus_if.halted}, 32'd1);
        check("hlt_ctl", ctl(), 32'h00);
        next();
        bus_if.halt_req = 1'b0;
        #2 check("hlt_rel_hlt", {31'd0, bus_if.halted}, 32'd1);
        next();
        check("hlt_exit_hlt", {31'd0, bus_if.halted}, 32'd0);
        check("hlt_exit_ctl", ctl(), 32'h3C);
        check("hlt_stall", {16'd0, bus_if.stall_cnt}, 32'd20);

        // Asynchronous reset during HALT
        bus_if.halt_req = 1'b1;
        next();
        check("hlt2_halted", {31'd0, bus_if.halted}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_halted", {31'd0, bus_if.halted}, 32'd0);
        check("arst_stall", {16'd0, bus_if.stall_cnt}, 32'd0);
        check("arst_flush", {16'd0, bus_if.flush_cnt}, 32'd0);
        check("arst_merr", {31'd0, bus_if.mem_err}, 32'd0);
        check("arst_ctl", ctl(), 32'h00);
        clear_inputs();
        #3 rst = 1'b1;
        next();
        #2 check("post_rst_ctl", ctl(), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives write-enables and clears for the PC, IF/ID, ID/EX and EX/MEM stage registers. It resolves four conditions: load-use hazards, taken-branch flushes, multi-cycle data-memory waits with a timeout, and a debug halt. It sits beside the stage registers, taking register addresses and control bits from the ID and EX stages and the handshake from the data-memory interface.

Parameters:
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before a forced release (range 1..255)
CNT_W, 16, width of the saturating performance counters

Ports:
clk  input  1  clock
rst  input  1  reset
id_addr1  input  5  rs address of the instruction in ID
id_addr2  input  5  rt address of the instruction in ID
id_uses2  input  1  ID instruction reads id_addr2
ex_addr_dst  input  5  destination register of the instruction in EX
ex_reg_rw  input  1  EX instruction writes the register file
ex_is_load  input  1  EX instruction is a load
br_taken  input  1  branch/jump resolved taken in EX
mem_req  input  1  MEM stage is accessing data memory this cycle
mem_ack  input  1  data memory completes the access
halt_req  input  1  debug halt request (level)
pc_we  output  1  PC write-enable
ifid_we  output  1  IF/ID write-enable
idex_we  output  1  ID/EX write-enable
exmem_we  output  1  EX/MEM and MEM/WB write-enable
ifid_clr  output  1  load a NOP into IF/ID
idex_clr  output  1  load a bubble (all control bits 0) into ID/EX
halted  output  1  controller is in HALT
mem_err  output  1  sticky flag: a memory timeout occurred
stall_cnt  output  CNT_W  saturating count of stalled cycles
flush_cnt  output  CNT_W  saturating count of branch flushes

Behaviour:
- Reset (rst low, asynchronous, active-low; clock clk): state=RUN, timeout counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. While reset is held, all *_we=0, ifid_clr=0, idex_clr=0, halted=0.
- Decode terms:
  - freeze = (state==MEM_WAIT && !mem_ack && !tmo) || (state==RUN && mem_req && !mem_ack) || state==HALT.
  - tmo = (state==MEM_WAIT && tcnt==MEM_TIMEOUT-1).
  - lu = ex_is_load && ex_reg_rw && ex_addr_dst!=0 && (ex_addr_dst==id_addr1 || (id_uses2 && ex_addr_dst==id_addr2)).
- Stall/flush outputs are combinational in the same cycle, with priority freeze > br_taken > lu:
  - freeze: all four *_we=0, both clr=0.
  - br_taken: all *_we=1, ifid_clr=1, idex_clr=1. A branch overrides a coincident lu, because the ID instruction is squashed anyway.
  - lu: pc_we=0, ifid_we=0, idex_we=1, idex_clr=1, exmem_we=1. This is exactly one bubble; the next cycle the load is in MEM and lu is false.
  - Otherwise: all *_we=1, both clr=0.
- FSM (registered):
  - RUN:
    - mem_req && !mem_ack -> MEM_WAIT, tcnt=0.
    - Otherwise, if halt_req && !mem_req -> HALT.
    - Otherwise stay in RUN.
    - A single-cycle access (mem_req && mem_ack) does not stall.
  - MEM_WAIT:
    - Each cycle tcnt++.
    - mem_ack -> RUN; that cycle is not frozen, and br_taken/lu rules apply to it.
    - tmo -> RUN and mem_err<=1; that cycle is released as if acked.
    - A simultaneous mem_ack and tmo counts as an ack; mem_err is not set.
    - halt_req is ignored until the wait ends.
  - HALT: full freeze, halted=1; !halt_req -> RUN. halted=0 in all other states.
- A br_taken held during freeze is not lost: EX is frozen, so br_taken is re-evaluated once freeze drops.
- Counters (registered, saturate at all-ones, no wrap):
  - stall_cnt += 1 when pc_we==0 and state!=HALT.
  - flush_cnt += 1 when br_taken is applied (not frozen).
- Reset mid-MEM_WAIT or mid-HALT returns to RUN immediately and clears mem_err and the counters.

Test Plan:
- Load-use: ex_is_load=1, ex_reg_rw=1, ex_addr_dst=5, id_addr1=5 for one cycle -> pc_we=0, ifid_we=0, idex_clr=1 that cycle; stall_cnt=1. Repeat with ex_addr_dst=0 -> no stall.
- id_addr2 match: ex_addr_dst=7, id_addr2=7, id_uses2=0 -> no stall; id_uses2=1 -> stall.
- Branch plus load-use in the same cycle -> ifid_clr=1, idex_clr=1, pc_we=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1 with mem_ack arriving on the 4th cycle -> 3 frozen cycles, all *_we=1 on the ack cycle, stall_cnt=3, mem_err=0.
- mem_req=1 with no ack and MEM_TIMEOUT=15 -> 15 frozen cycles (RUN entry cycle plus 14 in MEM_WAIT), release on the 16th cycle, mem_err=1 and sticky until reset.
- halt_req=1 while in RUN -> halted=1 next cycle, all *_we=0, stall_cnt unchanged; halt_req=0 -> RUN next cycle. Assert rst during HALT -> halted=0 and counters 0 asynchronously.
